// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and legal parameter bounds for seq_detector
package seq_pkg;
  typedef enum logic [1:0] {NOPAT, FILL, ARMED} statetype;
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  localparam int CW_MIN = 1;
  localparam int CW_MAX = 32;
endpackage

// File: rtl/shiftreg_en.sv
// shiftreg_en: N-bit left shift register with enable and synchronous clear
module shiftreg_en #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         d,
  output logic [N-1:0] q
);
  logic [N-1:0] q_q, q_d;
  // clear has priority over shift; new bit enters at the LSB
  always_comb q_d = clr ? '0 : en ? {q_q[N-2:0], d} : q_q;
  // history register
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/seq_detector.sv
// seq_detector: loadable N-bit serial pattern detector with saturating match count
module seq_detector
  import seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          a,
  input  logic          load,
  input  logic [N-1:0]  pattern,
  input  logic          overlap,
  input  logic          clr,
  output logic          y,
  output logic [CW-1:0] count,
  output logic          armed
);
  localparam int FW = $clog2(N);
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("seq_detector: N out of range");
  end
  if (CW < CW_MIN || CW > CW_MAX) begin : g_bad_cw
    $error("seq_detector: CW out of range");
  end
  statetype      state_q, state_d;
  logic [N-1:0]  pat_q, pat_d, hist;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic          y_q, armed_q;
  logic          match, restart, shift;
  shiftreg_en #(.N(N)) u_hist (
    .clk  (clk),
    .reset(reset),
    .en   (shift),
    .clr  (restart),
    .d    (a),
    .q    (hist)
  );
  // comparator, history control and next-state logic; load beats a same-cycle bit
  always_comb begin
    match   = state_q == ARMED && en && !load && {hist, a} == {hist[N-1], pat_q};
    restart = load || (match && !overlap);
    shift   = en && state_q != NOPAT && !restart;
    pat_d   = load ? pattern : pat_q;
    state_d = restart ? FILL :
              (state_q == FILL && en && fill_q == FW'(N - 2)) ? ARMED : state_q;
    fill_d  = restart ? '0 : (state_q == FILL && en) ? fill_q + 1'b1 : fill_q;
    count_d = clr ? '0 : (match && !(&count_q)) ? count_q + 1'b1 : count_q;
  end
  // FSM, pattern, fill counter, match counter and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= NOPAT;
      pat_q   <= '0;
      fill_q  <= '0;
      count_q <= '0;
      y_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      y_q     <= match;
      armed_q <= state_d == ARMED;
    end
  assign y     = y_q;
  assign count = count_q;
  assign armed = armed_q;
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: scoreboard bench for seq_detector (N=4/CW=8 and N=2/CW=2 instances)
module tb_seq_detector;
  typedef struct {
    logic y;
    int   cnt;
    logic armed;
    string tag;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic en = 1'b0, a = 1'b0, load = 1'b0, overlap = 1'b1, clr = 1'b0;
  logic [3:0] pat4 = 4'b1011;
  logic [1:0] pat2 = 2'b11;
  logic y4, armed4, y2, armed2;
  logic [7:0] count4;
  logic [1:0] count2;
  logic sel = 1'b0;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_detector #(.N(4), .CW(8)) dut4 (
    .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pat4),
    .overlap(overlap), .clr(clr), .y(y4), .count(count4), .armed(armed4)
  );
  seq_detector #(.N(2), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pat2),
    .overlap(overlap), .clr(clr), .y(y2), .count(count2), .armed(armed2)
  );
  // monitor: pops one expectation per presented output cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ay, aa;
      int ac;
      e = q.pop_front();
      ay = sel ? y2 : y4;
      aa = sel ? armed2 : armed4;
      ac = sel ? int'(count2) : int'(count4);
      checks++;
      if (ay !== e.y || ac != e.cnt || aa !== e.armed) begin
        errors++;
        $display("FAIL %s: got y=%b count=%0d armed=%b, expected y=%b count=%0d armed=%b",
                 e.tag, ay, ac, aa, e.y, e.cnt, e.armed);
      end
    end
  end
  task automatic cyc(input logic e_i, input logic a_i, input logic ld, input logic cl,
                     input logic ey, input int ec, input logic ea, input string tag);
    en = e_i; a = a_i; load = ld; clr = cl;
    @(posedge clk);
    q.push_back('{ey, ec, ea, tag});
    #1;
    en = 1'b0; load = 1'b0; clr = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    #12 reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, "reset_state");
    // overlapping 1011 on 1,0,1,1,0,1,1
    cyc(0, 0, 1, 0, 0, 0, 0, "ov_load");
    cyc(1, 1, 0, 0, 0, 0, 0, "ov_b1");
    cyc(1, 0, 0, 0, 0, 0, 0, "ov_b2");
    cyc(1, 1, 0, 0, 0, 0, 1, "ov_b3");
    cyc(1, 1, 0, 0, 1, 1, 1, "ov_b4_match");
    cyc(1, 0, 0, 0, 0, 1, 1, "ov_b5");
    cyc(1, 1, 0, 0, 0, 1, 1, "ov_b6");
    cyc(1, 1, 0, 0, 1, 2, 1, "ov_b7_match");
    // non-overlapping: armed low for three bits after the match
    overlap = 1'b0;
    cyc(0, 0, 1, 0, 0, 2, 0, "no_load");
    cyc(1, 1, 0, 0, 0, 2, 0, "no_b1");
    cyc(1, 0, 0, 0, 0, 2, 0, "no_b2");
    cyc(1, 1, 0, 0, 0, 2, 1, "no_b3");
    cyc(1, 1, 0, 0, 1, 3, 0, "no_b4_match");
    cyc(1, 0, 0, 0, 0, 3, 0, "no_b5");
    cyc(1, 1, 0, 0, 0, 3, 0, "no_b6");
    cyc(1, 1, 0, 0, 0, 3, 1, "no_b7_rearm");
    // gaps between bits, then load colliding with a completing bit
    overlap = 1'b1;
    cyc(0, 0, 1, 0, 0, 3, 0, "gap_load");
    cyc(1, 1, 0, 0, 0, 3, 0, "gap_b1");
    cyc(0, 1, 0, 0, 0, 3, 0, "gap_idle1");
    cyc(1, 0, 0, 0, 0, 3, 0, "gap_b2");
    cyc(0, 1, 0, 0, 0, 3, 0, "gap_idle2");
    cyc(1, 1, 0, 0, 0, 3, 1, "gap_b3");
    cyc(0, 0, 0, 0, 0, 3, 1, "gap_idle3");
    cyc(1, 1, 0, 0, 1, 4, 1, "gap_b4_match");
    cyc(1, 0, 0, 0, 0, 4, 1, "pre_b1");
    cyc(1, 1, 0, 0, 0, 4, 1, "pre_b2");
    cyc(1, 1, 1, 0, 0, 4, 0, "load_beats_bit");
    cyc(1, 1, 0, 0, 0, 4, 0, "after_load_fill");
    // reload mid-stream restarts history
    cyc(0, 0, 1, 0, 0, 4, 0, "rl_load1");
    cyc(1, 1, 0, 0, 0, 4, 0, "rl_b1");
    cyc(1, 0, 0, 0, 0, 4, 0, "rl_b2");
    cyc(1, 1, 0, 0, 0, 4, 1, "rl_b3");
    pat4 = 4'b0110;
    cyc(0, 0, 1, 0, 0, 4, 0, "rl_load2");
    cyc(1, 1, 0, 0, 0, 4, 0, "rl_c1");
    cyc(1, 1, 0, 0, 0, 4, 0, "rl_c2");
    cyc(1, 0, 0, 0, 0, 4, 1, "rl_c3");
    cyc(1, 0, 0, 0, 0, 4, 1, "rl_c4");
    cyc(1, 1, 0, 0, 0, 4, 1, "rl_c5");
    cyc(1, 1, 0, 0, 0, 4, 1, "rl_c6");
    cyc(1, 0, 0, 0, 1, 5, 1, "rl_c7_match");
    // asynchronous reset while armed
    pat4 = 4'b1011;
    cyc(0, 0, 1, 0, 0, 5, 0, "rs_load");
    cyc(1, 1, 0, 0, 0, 5, 0, "rs_b1");
    cyc(1, 0, 0, 0, 0, 5, 0, "rs_b2");
    cyc(1, 1, 0, 0, 0, 5, 1, "rs_b3");
    drain();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (y4 !== 1'b0 || count4 !== 8'd0 || armed4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got y=%b count=%0d armed=%b, expected 0 0 0", y4, count4, armed4);
    end
    #1 reset = 1'b0;
    cyc(1, 1, 0, 0, 0, 0, 0, "nopat_b1");
    cyc(1, 0, 0, 0, 0, 0, 0, "nopat_b2");
    cyc(1, 1, 0, 0, 0, 0, 0, "nopat_b3");
    cyc(1, 1, 0, 0, 0, 0, 0, "nopat_b4");
    drain();
    // N=2, CW=2 instance: saturation and clear priority
    sel = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0, "sat_load");
    cyc(1, 1, 0, 0, 0, 0, 1, "sat_b1");
    cyc(1, 1, 0, 0, 1, 1, 1, "sat_b2");
    cyc(1, 1, 0, 0, 1, 2, 1, "sat_b3");
    cyc(1, 1, 0, 0, 1, 3, 1, "sat_b4");
    cyc(1, 1, 0, 0, 1, 3, 1, "sat_b5_hold");
    cyc(1, 1, 0, 0, 1, 3, 1, "sat_b6_hold");
    cyc(1, 1, 0, 1, 1, 0, 1, "clr_with_match");
    cyc(0, 0, 0, 1, 0, 0, 1, "clr_idle");
    cyc(1, 1, 0, 0, 1, 1, 1, "after_clr_match");
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial pattern detector: the generalised successor to the fixed two-bit Moore/Mealy pattern FSMs. It compares a runtime-loadable N-bit pattern against a gated serial bit stream, in overlapping or non-overlapping mode. It emits a registered one-cycle match pulse and keeps a saturating match count. It sits on serial receive paths as a framing/sync-word detector.

## Interface
- N, default 4: pattern length in bits; legal range 2..16.
- CW, default 8: match counter width; legal range 1..32.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  bit-valid; `a` is sampled only when `en`=1
- a  input  1  serial data bit
- load  input  1  capture `pattern`, clear history and fill count
- pattern  input  N  pattern to detect; MSB is the first bit received
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after a match; sampled every cycle
- clr  input  1  synchronous clear of `count`
- y  output  1  registered match pulse
- count  output  CW  saturating number of matches
- armed  output  1  1 while state = ARMED

## Operation
- State register `state` holds one of: NOPAT (no pattern loaded), FILL (collecting history), ARMED (next valid bit can complete a match).
- Internal registers: `pat_r`[N-1:0]; `hist`[N-1:0], which shifts left with `a` into the LSB on `en`; `fill`, wide enough for 0..N-1.
- NOPAT: `en` is ignored and `y` never asserts. `load` captures the pattern, clears `hist` and `fill`, and moves the FSM to FILL.
- FILL: each `en` shifts `hist` and increments `fill`. When `fill` reaches N-1, the FSM moves to ARMED.
- ARMED: a match occurs when `en`=1 and {hist[N-2:0], a} == pat_r.
  - On a match with `overlap`=1: the FSM stays ARMED and `hist` shifts normally.
  - On a match with `overlap`=0: `hist` is cleared, `fill` is set to 0, and the FSM moves to FILL.
  - Without a match: `hist` shifts and the FSM stays ARMED.
- `count` increments by 1 on each match and saturates at 2^CW-1. It does not wrap.
- `load` and `en` in the same cycle: `load` wins and the bit is discarded. A load from FILL or ARMED is a full restart into FILL. `count` is untouched.
- `clr` and a match in the same cycle: `clr` wins and `count` becomes 0. `y` still pulses.
- `clr` has no effect on `state`, `hist`, or `pat_r`.
- Reset, asynchronous, at any time including mid-stream:
  - `state`=NOPAT.
  - `pat_r`, `hist`, `fill`, and `count` are all 0.
  - `y`=0 and `armed`=0.
- All outputs reset to 0.

## Timing
- `y` is asserted for exactly one cycle, on the clock edge after the edge that samples the completing bit (latency 1).
- `count` updates on the same edge that asserts `y`.
- Back-to-back matches in overlap mode produce consecutive `y` pulses, one cycle apart per valid bit.
- `en` may be deasserted for any number of cycles. History is held and gaps do not break a match.
- A newly loaded pattern takes effect for the first `en` bit in the cycle after `load`.
- A match needs at least N valid bits after `load`. In non-overlap mode, it also needs at least N valid bits after the previous match.
- `armed` is a registered decode of `state`. It rises on the edge that enters ARMED.

## Structure
- Shared package `seq_pkg`:
  - typedef enum logic [1:0] {NOPAT, FILL, ARMED} statetype;
  - localparam constants for the legal N and CW bounds.
- Elaboration-time assertions check N and CW against those bounds.
- One sub-module, `shiftreg_en` #(N): an N-bit shift register with enable and synchronous clear, reset asynchronously. It holds `hist`.
- Everything else goes in `seq_detector`: the FSM, `fill`, the comparator, and the counter.

## Test plan
- Basic overlap: N=4, load 4'b1011, overlap=1, `en`=1, stream 1,0,1,1,0,1,1 → `y` pulses the cycle after bit 4 and again the cycle after bit 7; `count`=2.
- Non-overlap: same stream with overlap=0 → only one `y`, after bit 4; `count`=1; `armed` drops for 3 cycles after the match, then re-arms.
- Gaps and precedence: insert `en`=0 gaps between every bit of 1011 → one match. Then assert `load` together with a completing bit → no `y`, FSM in FILL.
- Saturation and clear: CW=2, pattern 2'b11 (N=2), overlap=1, stream of six 1s → `count` sticks at 3. Assert `clr` in the same cycle as a match → `count`=0 and `y`=1.
- Reset mid-stream: assert `reset` asynchronously between clock edges while ARMED after 1,0,1 → immediately `y`=0, `count`=0, `armed`=0. Then a stream of 1,0,1,1 with no `load` → no `y` (NOPAT).
- Pattern reload: load 1011, stream 1,0,1, load 0110, stream 1,1,0 → no `y`. Continue 0,1,1,0 → one `y`.
